axis_frame_length_fifo: RTL and testbench
=========================================

// Module: axis_frame_length_fifo
// PURPOSE
//  Passive monitor on an AXI-stream receive path (tap between MAC and rx FIFO). Counts bytes per
//  frame from tkeep, tags each frame good/bad/oversize and queues one length record per frame in
//  a single-clock FWFT FIFO for the packet-parsing logic. Successor to the 8-bit fixed length
//  tracker: parametrised data width, depth, length width, max-length check and drop mode.
// PARAMETERS
//  DATA_WIDTH      8     monitored tdata width (tdata itself not needed; sets KEEP_WIDTH)
//  KEEP_WIDTH      DATA_WIDTH/8  tkeep width; 1 => every beat counts 1 byte
//  LEN_WIDTH       16    length record width; accumulator saturates at 2**LEN_WIDTH-1
//  DEPTH           64    record FIFO depth, power of two, >=2
//  MAX_LEN         1522  frames with length > MAX_LEN flagged oversize
//  DROP_BAD_FRAME  1     1: bad/oversize frames not queued; 0: queued with flags set
// PORTS
//  clk              in   1              single clock for all logic
//  rst_n            in   1              synchronous, active-low reset
//  mon_axis_tkeep   in   KEEP_WIDTH     monitored byte enables
//  mon_axis_tvalid  in   1              monitored valid
//  mon_axis_tready  in   1              monitored ready (observe only; block never stalls stream)
//  mon_axis_tlast   in   1              monitored end of frame
//  mon_axis_tuser   in   1              bad-frame flag, sampled on tlast beat
//  m_len_tdata      out  LEN_WIDTH      frame length in bytes
//  m_len_bad        out  1              record flag: tuser was 1 on last beat
//  m_len_oversize   out  1              record flag: length > MAX_LEN (or saturated)
//  m_len_tvalid     out  1              record available
//  m_len_tready     in   1              record consumed
//  frame_active     out  1              high while a frame is in progress (FSM state ACTIVE)
//  status_overflow  out  1              1-cycle pulse: record lost, FIFO full
//  status_dropped   out  1              1-cycle pulse: record discarded by DROP_BAD_FRAME
//  fifo_level       out  $clog2(DEPTH)+1  records held
// BEHAVIOUR
//  - Beat = mon_axis_tvalid && mon_axis_tready. Beat bytes = popcount(tkeep) (KEEP_WIDTH==1: 1).
//    Zero-keep beats add 0 and are legal.
//  - acc_next = acc + bytes, computed LEN_WIDTH+1 wide, clamped to 2**LEN_WIDTH-1.
//    oversize = (acc_next > MAX_LEN) || clamp occurred.
//  - FSM: IDLE -> ACTIVE on beat without tlast; ACTIVE -> IDLE on tlast beat; IDLE stays IDLE on
//    single-beat frame (tlast on first beat). acc <= 0 on every tlast beat, else acc <= acc_next.
//  - On tlast beat form record {acc_next, tuser, oversize}. If DROP_BAD_FRAME && (bad||oversize):
//    not written, status_dropped pulses next cycle. Else written; visible on m_len_tvalid the
//    cycle after the tlast beat (1-cycle latency), fifo_level increments same edge.
//  - Full: write with level==DEPTH and no pop that cycle -> record lost, status_overflow pulses
//    next cycle, FIFO unchanged. Write while full with simultaneous pop -> accepted.
//  - Empty: m_len_tvalid=0, m_len_tdata/flags hold last value (don't-care). Pop only on
//    tvalid&&tready; simultaneous push+pop on non-full/non-empty keeps level constant.
//  - Pointers log2(DEPTH) bits, wrap naturally; full/empty from level counter.
//  - Zero-length frame (tlast beat, all acc 0) is queued with length 0.
//  - Reset (rst_n==0 at clk edge): acc=0, FSM IDLE, FIFO emptied, all outputs 0, pulses 0.
//    Frame in progress at reset is discarded; beats after release start a new frame count.
// STRUCTURE
//  - Package frame_len_pkg: typedef len_rec_t {len, bad, oversize} parameterised via
//    LEN_WIDTH localparam helper, function popcount(keep), enum fsm_t {IDLE, ACTIVE}.
//  - Sub-module sync_fifo_fwft (WIDTH=LEN_WIDTH+2, DEPTH): registered write, first-word
//    fall-through read, level output, accept-on-full-with-pop. Top holds FSM, accumulator, flags.
// TESTING
//  1. DATA_WIDTH=64: 8 beats keep=FF, last keep=0F, tuser=0 -> one record len=60, flags 0, 1 cycle after tlast.
//  2. DATA_WIDTH=8, 1523-byte frame -> DROP_BAD_FRAME=1: no record, status_dropped pulse;
//     DROP_BAD_FRAME=0: record len=1523 oversize=1.
//  3. tuser=1 on last beat, DROP_BAD_FRAME=0 -> record bad=1; =1 -> dropped, fifo_level unchanged.
//  4. DEPTH=4, m_len_tready=0, 5 single-beat frames -> level=4, 5th gives status_overflow;
//     repeat with tready=1 on 5th tlast cycle -> accepted, level stays 4.
//  5. LEN_WIDTH=8, 300 one-byte beats -> len=255, oversize=1 (saturation).
//  6. rst_n low mid-frame after 10 bytes, then 5-byte frame -> single record len=5; all outputs 0 during reset.

Source files
------------

// File: rtl/frame_len_pkg.sv
// Shared types and helpers for the AXI-stream frame length monitor.
package frame_len_pkg;

  // Widest tkeep the byte counter handles (512-bit data path).
  localparam int unsigned MaxKeepWidth = 64;
  // Flag bits carried next to the length in every record: bad, oversize.
  localparam int unsigned RecFlagWidth = 2;

  typedef enum logic [0:0] {
    IDLE,
    ACTIVE
  } fsm_t;

  // Record width for a given length field width.
  function automatic int unsigned rec_width(input int unsigned len_width);
    return len_width + RecFlagWidth;
  endfunction

  // Number of set byte enables; callers zero-extend narrower tkeep vectors.
  function automatic int unsigned popcount(input logic [MaxKeepWidth-1:0] keep);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MaxKeepWidth; i++) begin
      cnt += 32'(keep[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with level counter.
// A write while full is still accepted when a pop happens in the same cycle.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_valid_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  output logic                   wr_lost_o,
  output logic                   rd_valid_o,
  input  logic                   rd_ready_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned PtrWidth   = $clog2(DEPTH);
  localparam int unsigned LevelWidth = PtrWidth + 1;
  localparam logic [LevelWidth-1:0] LevelFull = LevelWidth'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LevelWidth-1:0] level_q, level_d;
  logic                  empty, full, push, pop;

  // Push/pop decode and next pointer/level values; pointers wrap naturally.
  always_comb begin
    empty     = (level_q == '0);
    full      = (level_q == LevelFull);
    pop       = rd_ready_i & ~empty;
    push      = wr_valid_i & (~full | pop);
    wr_lost_o = wr_valid_i & full & ~pop;
    wr_ptr_d  = push ? wr_ptr_q + PtrWidth'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + PtrWidth'(1) : rd_ptr_q;
    level_d   = level_q + LevelWidth'(push) - LevelWidth'(pop);
  end

  // Storage and pointers; storage is cleared so read data is 0 out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rd_valid_o = ~empty;
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign level_o    = level_q;

endmodule

// File: rtl/axis_frame_length_fifo.sv
// Passive AXI-stream monitor: counts bytes per frame, flags bad/oversize frames
// and queues one length record per frame for the packet parser.
module axis_frame_length_fifo
  import frame_len_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned KEEP_WIDTH     = (DATA_WIDTH / 8 > 0) ? DATA_WIDTH / 8 : 1,
  parameter int unsigned LEN_WIDTH      = 16,
  parameter int unsigned DEPTH          = 64,
  parameter int unsigned MAX_LEN        = 1522,
  parameter bit          DROP_BAD_FRAME = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [KEEP_WIDTH-1:0]  mon_axis_tkeep,
  input  logic                   mon_axis_tvalid,
  input  logic                   mon_axis_tready,
  input  logic                   mon_axis_tlast,
  input  logic                   mon_axis_tuser,
  output logic [LEN_WIDTH-1:0]   m_len_tdata,
  output logic                   m_len_bad,
  output logic                   m_len_oversize,
  output logic                   m_len_tvalid,
  input  logic                   m_len_tready,
  output logic                   frame_active,
  output logic                   status_overflow,
  output logic                   status_dropped,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int unsigned RecWidth = rec_width(LEN_WIDTH);
  localparam logic [LEN_WIDTH-1:0] LenMax = '1;

  typedef struct packed {
    logic [LEN_WIDTH-1:0] len;
    logic                 bad;
    logic                 oversize;
  } len_rec_t;

  fsm_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0] acc_q, acc_d;
  logic                 dropped_q, dropped_d;
  logic                 overflow_q, overflow_d;

  logic [LEN_WIDTH:0]   beat_bytes;
  logic [LEN_WIDTH:0]   acc_sum;
  logic [LEN_WIDTH-1:0] acc_next;
  logic                 beat, clamp, oversize, rec_done, drop, wr_valid, wr_lost;
  len_rec_t             wr_rec, rd_rec;

  // A one-byte-lane bus counts every beat as one byte; tkeep carries no information.
  if (KEEP_WIDTH == 1) begin : g_keep_single
    logic unused_keep;
    assign unused_keep = ^mon_axis_tkeep;
    assign beat_bytes  = (LEN_WIDTH + 1)'(1);
  end else begin : g_keep_multi
    assign beat_bytes = (LEN_WIDTH + 1)'(popcount(MaxKeepWidth'(mon_axis_tkeep)));
  end

  // Saturating accumulator, record formation and frame FSM next state.
  always_comb begin
    beat     = mon_axis_tvalid & mon_axis_tready;
    acc_sum  = {1'b0, acc_q} + beat_bytes;
    clamp    = acc_sum[LEN_WIDTH];
    acc_next = clamp ? LenMax : acc_sum[LEN_WIDTH-1:0];
    oversize = clamp || (32'(acc_next) > MAX_LEN);
    rec_done = beat & mon_axis_tlast;
    drop     = DROP_BAD_FRAME && (mon_axis_tuser || oversize);
    wr_valid = rec_done & ~drop;

    wr_rec.len      = acc_next;
    wr_rec.bad      = mon_axis_tuser;
    wr_rec.oversize = oversize;

    state_d = state_q;
    acc_d   = acc_q;
    if (beat) begin
      acc_d   = mon_axis_tlast ? '0 : acc_next;
      state_d = mon_axis_tlast ? IDLE : ACTIVE;
    end

    dropped_d  = rec_done & drop;
    overflow_d = wr_lost;
  end

  // Frame state, byte count and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      dropped_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      dropped_q  <= dropped_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (RecWidth),
    .DEPTH (DEPTH)
  ) u_rec_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid_i (wr_valid),
    .wr_data_i  (wr_rec),
    .wr_lost_o  (wr_lost),
    .rd_valid_o (m_len_tvalid),
    .rd_ready_i (m_len_tready),
    .rd_data_o  (rd_rec),
    .level_o    (fifo_level)
  );

  assign m_len_tdata     = rd_rec.len;
  assign m_len_bad       = rd_rec.bad;
  assign m_len_oversize  = rd_rec.oversize;
  assign frame_active    = (state_q == ACTIVE);
  assign status_dropped  = dropped_q;
  assign status_overflow = overflow_q;

endmodule

// File: tb/tb_axis_frame_length_fifo.sv
// Bench for axis_frame_length_fifo: four differently parameterised instances share
// one stimulus stream and are compared every cycle against a queue-based model.
`timescale 1ns/1ps
module tb_axis_frame_length_fifo;

  localparam int unsigned NI   = 4;
  localparam int unsigned MAXL = 1522;
  // Instances: A 64b/len16/depth4/drop, B 64b/len16/depth4/keep, C 8b/len8/depth4/keep,
  // D 8b/len16/depth8/drop.
  localparam int unsigned KW   [NI] = '{8, 8, 1, 1};
  localparam int unsigned LMAX [NI] = '{65535, 65535, 255, 65535};
  localparam int unsigned DEP  [NI] = '{4, 4, 4, 8};
  localparam bit          DROP [NI] = '{1'b1, 1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] tkeep;
  logic       tvalid, tready, tlast, tuser, m_ready;

  logic [15:0]   a_len, b_len, d_len;
  logic [7:0]    c_len;
  logic [2:0]    a_lvl, b_lvl, c_lvl;
  logic [3:0]    d_lvl;
  logic [NI-1:0] o_bad, o_over, o_tvalid, o_active, o_ovf, o_drop;
  int unsigned   o_len [NI];
  int unsigned   o_lvl [NI];

  always_comb begin
    o_len[0] = 32'(a_len);
    o_len[1] = 32'(b_len);
    o_len[2] = 32'(c_len);
    o_len[3] = 32'(d_len);
    o_lvl[0] = 32'(a_lvl);
    o_lvl[1] = 32'(b_lvl);
    o_lvl[2] = 32'(c_lvl);
    o_lvl[3] = 32'(d_lvl);
  end

  axis_frame_length_fifo #(
    .DATA_WIDTH(64), .LEN_WIDTH(16), .DEPTH(4), .MAX_LEN(MAXL), .DROP_BAD_FRAME(1'b1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .mon_axis_tkeep(tkeep), .mon_axis_tvalid(tvalid),
    .mon_axis_tready(tready), .mon_axis_tlast(tlast), .mon_axis_tuser(tuser),
    .m_len_tdata(a_len), .m_len_bad(o_bad[0]), .m_len_oversize(o_over[0]),
    .m_len_tvalid(o_tvalid[0]), .m_len_tready(m_ready), .frame_active(o_active[0]),
    .status_overflow(o_ovf[0]), .status_dropped(o_drop[0]), .fifo_level(a_lvl)
  );

  axis_frame_length_fifo #(
    .DATA_WIDTH(64), .LEN_WIDTH(16), .DEPTH(4), .MAX_LEN(MAXL), .DROP_BAD_FRAME(1'b0)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .mon_axis_tkeep(tkeep), .mon_axis_tvalid(tvalid),
    .mon_axis_tready(tready), .mon_axis_tlast(tlast), .mon_axis_tuser(tuser),
    .m_len_tdata(b_len), .m_len_bad(o_bad[1]), .m_len_oversize(o_over[1]),
    .m_len_tvalid(o_tvalid[1]), .m_len_tready(m_ready), .frame_active(o_active[1]),
    .status_overflow(o_ovf[1]), .status_dropped(o_drop[1]), .fifo_level(b_lvl)
  );

  axis_frame_length_fifo #(
    .DATA_WIDTH(8), .LEN_WIDTH(8), .DEPTH(4), .MAX_LEN(MAXL), .DROP_BAD_FRAME(1'b0)
  ) u_dut_c (
    .clk(clk), .rst_n(rst_n), .mon_axis_tkeep(tkeep[0]), .mon_axis_tvalid(tvalid),
    .mon_axis_tready(tready), .mon_axis_tlast(tlast), .mon_axis_tuser(tuser),
    .m_len_tdata(c_len), .m_len_bad(o_bad[2]), .m_len_oversize(o_over[2]),
    .m_len_tvalid(o_tvalid[2]), .m_len_tready(m_ready), .frame_active(o_active[2]),
    .status_overflow(o_ovf[2]), .status_dropped(o_drop[2]), .fifo_level(c_lvl)
  );

  axis_frame_length_fifo #(
    .DATA_WIDTH(8), .LEN_WIDTH(16), .DEPTH(8), .MAX_LEN(MAXL), .DROP_BAD_FRAME(1'b1)
  ) u_dut_d (
    .clk(clk), .rst_n(rst_n), .mon_axis_tkeep(tkeep[0]), .mon_axis_tvalid(tvalid),
    .mon_axis_tready(tready), .mon_axis_tlast(tlast), .mon_axis_tuser(tuser),
    .m_len_tdata(d_len), .m_len_bad(o_bad[3]), .m_len_oversize(o_over[3]),
    .m_len_tvalid(o_tvalid[3]), .m_len_tready(m_ready), .frame_active(o_active[3]),
    .status_overflow(o_ovf[3]), .status_dropped(o_drop[3]), .fifo_level(d_lvl)
  );

  // Reference model: one record queue per instance plus the running frame byte count.
  typedef struct packed {
    logic [15:0] len;
    logic        bad;
    logic        over;
  } rec_t;

  rec_t        mq    [NI][$];
  int unsigned macc  [NI];
  bit          mact  [NI];
  bit          mdrop [NI];
  bit          movf  [NI];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input int idx, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, idx, obs, exp);
    end
  endtask

  // Advance the model by one clock using the current inputs, clock the DUTs, compare.
  task automatic step();
    bit in_rst;
    in_rst = !rst_n;
    for (int i = 0; i < NI; i++) begin
      bit          pop;
      bit          push;
      bit          sat;
      int unsigned tot;
      rec_t        r;
      mdrop[i] = 1'b0;
      movf[i]  = 1'b0;
      push     = 1'b0;
      r        = '0;
      if (in_rst) begin
        mq[i].delete();
        macc[i] = 0;
        mact[i] = 1'b0;
      end else begin
        pop = (mq[i].size() != 0) && m_ready;
        if (tvalid && tready) begin
          tot = macc[i] + ((KW[i] == 1) ? 1 : $countones(tkeep));
          sat = (tot > LMAX[i]);
          if (sat) tot = LMAX[i];
          if (tlast) begin
            r.len  = 16'(tot);
            r.bad  = tuser;
            r.over = sat || (tot > MAXL);
            if (DROP[i] && (r.bad || r.over)) mdrop[i] = 1'b1;
            else if ((mq[i].size() == DEP[i]) && !pop) movf[i] = 1'b1;
            else push = 1'b1;
          end
          macc[i] = tlast ? 0 : tot;
          mact[i] = !tlast;
        end
        if (pop) void'(mq[i].pop_front());
        if (push) mq[i].push_back(r);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("level", i, 64'(o_lvl[i]), 64'(mq[i].size()));
      chk("tvalid", i, 64'(o_tvalid[i]), 64'(mq[i].size() != 0));
      chk("frame_active", i, 64'(o_active[i]), 64'(mact[i]));
      chk("status_dropped", i, 64'(o_drop[i]), 64'(mdrop[i]));
      chk("status_overflow", i, 64'(o_ovf[i]), 64'(movf[i]));
      if (in_rst) begin
        chk("rst_len", i, 64'(o_len[i]), 64'd0);
        chk("rst_bad", i, 64'(o_bad[i]), 64'd0);
        chk("rst_over", i, 64'(o_over[i]), 64'd0);
      end else if (mq[i].size() != 0) begin
        chk("len", i, 64'(o_len[i]), 64'(mq[i][0].len));
        chk("bad", i, 64'(o_bad[i]), 64'(mq[i][0].bad));
        chk("oversize", i, 64'(o_over[i]), 64'(mq[i][0].over));
      end
    end
  endtask

  task automatic beat(input logic [7:0] k, input bit last, input bit user);
    tvalid = 1'b1;
    tready = 1'b1;
    tkeep  = k;
    tlast  = last;
    tuser  = user;
    step();
    tvalid = 1'b0;
    tlast  = 1'b0;
    tuser  = 1'b0;
  endtask

  task automatic frame(input int nbeats, input logic [7:0] k, input logic [7:0] klast,
                       input bit user);
    for (int b = 0; b < nbeats; b++) begin
      if (b == nbeats - 1) beat(klast, 1'b1, user);
      else beat(k, 1'b0, 1'b0);
    end
  endtask

  task automatic drain();
    m_ready = 1'b1;
    repeat (9) step();
    m_ready = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    tkeep  = '0;
    tvalid = 1'b0;
    tready = 1'b1;
    tlast  = 1'b0;
    tuser  = 1'b0;
    m_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // 7 full beats + 0x0F: 60 bytes on the 64-bit instances, 8 beats on the 8-bit ones.
    frame(8, 8'hFF, 8'h0F, 1'b0);
    chk("t1_len_a", 0, 64'(o_len[0]), 64'd60);
    chk("t1_len_c", 2, 64'(o_len[2]), 64'd8);
    drain();

    // 1523 bytes: dropped with DROP_BAD_FRAME, oversize otherwise; 8-bit length saturates.
    frame(1523, 8'h01, 8'h01, 1'b0);
    chk("t2_drop_a", 0, 64'(o_drop[0]), 64'd1);
    chk("t2_len_b", 1, 64'(o_len[1]), 64'd1523);
    chk("t2_over_b", 1, 64'(o_over[1]), 64'd1);
    chk("t5_len_c", 2, 64'(o_len[2]), 64'd255);
    chk("t5_over_c", 2, 64'(o_over[2]), 64'd1);
    drain();
    frame(1522, 8'h01, 8'h01, 1'b0);
    chk("max_len_a", 0, 64'(o_len[0]), 64'd1522);
    chk("max_over_a", 0, 64'(o_over[0]), 64'd0);
    drain();

    // Bad frame: flagged on B, dropped on A with level unchanged.
    frame(3, 8'hFF, 8'hFF, 1'b1);
    chk("t3_bad_b", 1, 64'(o_bad[1]), 64'd1);
    chk("t3_lvl_a", 0, 64'(o_lvl[0]), 64'd0);
    drain();

    // Fill depth-4 FIFOs, overflow on the fifth, then push while full with a pop.
    for (int f = 0; f < 5; f++) frame(1, 8'hFF, 8'hFF, 1'b0);
    chk("t4_ovf_a", 0, 64'(o_ovf[0]), 64'd1);
    chk("t4_lvl_a", 0, 64'(o_lvl[0]), 64'd4);
    m_ready = 1'b1;
    frame(1, 8'hFF, 8'hFF, 1'b0);
    m_ready = 1'b0;
    chk("t4_ovf_b", 1, 64'(o_ovf[1]), 64'd0);
    chk("t4_lvl_b", 1, 64'(o_lvl[1]), 64'd4);
    drain();

    // Zero-length frame on the wide instances.
    frame(1, 8'h00, 8'h00, 1'b0);
    chk("zero_len_b", 1, 64'(o_len[1]), 64'd0);
    chk("zero_lvl_b", 1, 64'(o_lvl[1]), 64'd1);

    // Reset mid-frame discards the partial count.
    for (int b = 0; b < 10; b++) beat(8'h01, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    frame(5, 8'h01, 8'h01, 1'b0);
    chk("t6_len_b", 1, 64'(o_len[1]), 64'd5);
    chk("t6_lvl_b", 1, 64'(o_lvl[1]), 64'd1);
    drain();

    // Random traffic against the model.
    repeat (600) begin
      tvalid  = ($urandom_range(0, 3) != 0);
      tready  = ($urandom_range(0, 4) != 0);
      tkeep   = 8'($urandom);
      tlast   = ($urandom_range(0, 5) == 0);
      tuser   = ($urandom_range(0, 7) == 0);
      m_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
